// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller and its datapath:
// FSM state codes, supported opcodes, ALU operation codes and select values.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BEQ    = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   function automatic logic op_supported(input logic [6:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_ITYPE) || (op == OP_BEQ) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus funct3/funct7 onto the datapath ALU operation code.
module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       op_5,
   input  logic       funct7,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNC: begin
            case (funct3)
               // Only R-type (op[5]=1) can encode sub; addi with Instr[30] set stays add.
               3'b000:  alu_control = (op_5 & funct7) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle datapath, plus immediate-format decode.
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       CLK,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       RegWrite,
   output logic [3:0] State,
   output logic       IllegalOp
);

   state_t     state_q, state_d;
   logic       pc_update, branch;
   logic       ir_write, reg_write, mem_write, illegal;
   logic [1:0] alu_op;

   always_ff @(posedge CLK) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = S_FETCH;
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
      alu_op    = ALUOP_ADD;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      case (state_q)
         S_FETCH: begin
            state_d   = S_DECODE;
            ir_write  = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            pc_update = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            illegal = ~op_supported(op);
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTER;
               OP_ITYPE:     state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            state_d = S_MEMWB;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTER: begin
            state_d = S_ALUWB;
            ALUSrcA = 2'b10;
            alu_op  = ALUOP_FUNC;
         end
         S_EXECUTEI: begin
            state_d = S_ALUWB;
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = ALUOP_FUNC;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
         end
         S_JAL: begin
            state_d   = S_ALUWB;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // Enables are masked during reset so a mid-instruction reset cannot corrupt state.
   assign PCWrite   = ~rst & (pc_update | (branch & Zero));
   assign IRWrite   = ~rst & ir_write;
   assign RegWrite  = ~rst & reg_write;
   assign MemWrite  = ~rst & mem_write;
   assign IllegalOp = ~rst & illegal;
   assign State     = state_q;

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .op_5        (op[5]),
      .funct7      (funct7),
      .alu_control (ALUControl)
   );

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port op, input, 7 bits: Instr[6:0], the opcode.
REQ-004 SHALL have port funct3, input, 3 bits: Instr[14:12].
REQ-005 SHALL have port funct7, input, 1 bit: Instr[30].
REQ-006 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port PCWrite, output, 1 bit: PC register enable.
REQ-008 SHALL have port AdrSrc, output, 1 bit: memory address select (0 = PC, 1 = result).
REQ-009 SHALL have port MemWrite, output, 1 bit: unified memory write enable.
REQ-010 SHALL have port IRWrite, output, 1 bit: instruction register enable.
REQ-011 SHALL have port ResultSrc, output, 2 bits: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-012 SHALL have port ALUSrcA, output, 2 bits: 00 = PC, 01 = OldPC, 10 = rs1 data.
REQ-013 SHALL have port ALUSrcB, output, 2 bits: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
REQ-014 SHALL have port ImmSrc, output, 2 bits: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-015 SHALL have port ALUControl, output, 3 bits: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 SHALL have port RegWrite, output, 1 bit: register file write enable.
REQ-017 SHALL have port State, output, 4 bits: current state code, for debug.
REQ-018 SHALL have port IllegalOp, output, 1 bit: one-cycle pulse in DECODE when op is unsupported.

Function
REQ-019 SHALL implement a Moore FSM with these states and codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10.
REQ-020 SHALL use these transitions:
 - FETCH -> DECODE.
 - DECODE -> MEMADR on lw (0000011) or sw (0100011).
 - DECODE -> EXECUTER on 0110011; -> EXECUTEI on 0010011; -> BEQ on 1100011; -> JAL on 1101111.
 - DECODE -> FETCH on any other op.
 - MEMADR -> MEMREAD when op = lw, else -> MEMWRITE.
 - MEMREAD -> MEMWB.
 - EXECUTER, EXECUTEI, JAL -> ALUWB.
 - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
 - Unused codes 11..15 -> FETCH.
REQ-021 SHALL drive these per-state outputs (any signal not listed is 0 / 00):
 - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1, ALUOp=00.
 - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
 - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
 - MEMREAD: AdrSrc=1.
 - MEMWB: ResultSrc=01, RegWrite=1.
 - MEMWRITE: AdrSrc=1, MemWrite=1.
 - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
 - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
 - ALUWB: RegWrite=1.
 - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1.
 - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-022 SHALL compute PCWrite = PCUpdate | (Branch & Zero), with Zero sampled combinationally in BEQ.
REQ-023 SHALL decode ImmSrc combinationally from op alone:
 - lw and I-type (0010011) -> 00.
 - sw -> 01.
 - beq -> 10.
 - jal -> 11.
 - all others -> 00.
REQ-024 SHALL decode ALUControl as follows:
 - ALUOp=00 -> 000.
 - ALUOp=01 -> 001.
 - ALUOp=10, funct3=000 -> 001 when op[5]&funct7 = 1, else 000.
 - ALUOp=10, funct3=010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
REQ-025 SHALL make instruction latency 3 cycles for beq; 4 cycles for R-type, I-type, jal and sw; 5 cycles for lw.
REQ-026 SHALL assert IllegalOp only in DECODE with an unsupported op; no write enable is asserted for that instruction.

Reset
REQ-027 SHALL load State=FETCH on any rising CLK edge where rst=1, including mid-instruction.
REQ-028 SHALL force PCWrite, IRWrite, RegWrite, MemWrite and IllegalOp to 0 combinationally while rst=1.
REQ-029 SHALL begin the first FETCH on the first edge after rst deasserts; all other outputs then follow REQ-021.

Structure
REQ-030 SHALL place the state codes, the six opcode constants and the ALUControl codes in a shared package used by the datapath.
REQ-031 SHALL split the ALUOp/funct3/funct7 to ALUControl decode into the sub-module alu_decoder; the FSM and ImmSrc decode stay in multicycle_controller.

Verification
REQ-032 SHALL check lw: op=0000011 -> State 0,1,2,3,4,0; RegWrite=1 only in state 4; AdrSrc=1 in state 3.
REQ-033 SHALL check sw: op=0100011 -> State 0,1,2,5,0; MemWrite=1 only in state 5; ImmSrc=01 throughout.
REQ-034 SHALL check sub: op=0110011, funct3=000, funct7=1 -> ALUControl=001 in EXECUTER; with funct3=010 -> 101.
REQ-035 SHALL check beq: op=1100011 with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0; both return to FETCH next cycle.
REQ-036 SHALL check mid-instruction reset: rst=1 in MEMREAD -> MemWrite, RegWrite, IRWrite and PCWrite are 0 during reset; State=0 after the edge.
REQ-037 SHALL check an illegal op: op=0000000 -> IllegalOp=1 for one cycle in DECODE; next State=0; no write enable asserted.
